// File: rtl/rv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv_decode_stage
// Purpose  : Registered RV32IM decode with a one-entry skid buffer and flush.
// Revision : 1.0 - initial release
// ============================================================================
module rv_decode_stage #(
    parameter int PC_W   = 32,
    parameter bit EN_M   = 1'b1,
    parameter bit EN_SYS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_instr_i,
    input  logic [PC_W-1:0] in_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [PC_W-1:0] out_pc_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      funct3_o,
    output logic [31:0]     imm_o,
    output logic            rd_we_o,
    output logic [2:0]      wb_sel_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic [1:0]      mem_size_o,
    output logic            mem_sext_o,
    output logic            is_branch_o,
    output logic            is_jal_o,
    output logic            is_jalr_o,
    output logic            is_muldiv_o,
    output logic            is_csr_o,
    output logic            is_ecall_o,
    output logic            is_ebreak_o,
    output logic            is_mret_o,
    output logic            illegal_o
);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] c_WB_ALU = 3'b000;
    localparam logic [2:0] c_WB_IMM = 3'b001;
    localparam logic [2:0] c_WB_PC4 = 3'b011;
    localparam logic [2:0] c_WB_MEM = 3'b100;
    localparam logic [2:0] c_WB_CSR = 3'b101;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [31:0]     imm;
        logic            rd_we;
        logic [2:0]      wb_sel;
        logic            mem_read;
        logic            mem_write;
        logic [1:0]      mem_size;
        logic            mem_sext;
        logic            is_branch;
        logic            is_jal;
        logic            is_jalr;
        logic            is_muldiv;
        logic            is_csr;
        logic            is_ecall;
        logic            is_ebreak;
        logic            is_mret;
        logic            illegal;
    } dec_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [1:0]  w_size;
    logic        w_legal;
    logic        w_accept;
    dec_t        w_dec;

    state_e state_q, state_d;
    dec_t   out_q, out_d, skid_q, skid_d;
    logic   ready_q;

    assign w_opcode = in_instr_i[6:0];
    assign w_funct3 = in_instr_i[14:12];
    assign w_funct7 = in_instr_i[31:25];
    assign w_imm_i  = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
    assign w_imm_s  = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
    assign w_imm_b  = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                       in_instr_i[30:25], in_instr_i[11:8], 1'b0};
    assign w_imm_u  = {in_instr_i[31:12], 12'b0};
    assign w_imm_j  = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                       in_instr_i[20], in_instr_i[30:21], 1'b0};
    assign w_size   = (w_funct3[1:0] == 2'b00) ? 2'b11 :
                      (w_funct3[1:0] == 2'b01) ? 2'b01 : 2'b00;

    always_comb begin
        w_dec        = '0;
        w_legal      = 1'b0;
        w_dec.pc     = in_pc_i;
        w_dec.rs1    = in_instr_i[19:15];
        w_dec.rs2    = in_instr_i[24:20];
        w_dec.rd     = in_instr_i[11:7];
        w_dec.funct3 = w_funct3;
        case (w_opcode)
            c_OP_LUI: begin
                w_legal      = 1'b1;
                w_dec.rd_we  = 1'b1;
                w_dec.wb_sel = c_WB_IMM;
                w_dec.imm    = w_imm_u;
            end
            c_OP_AUIPC: begin
                w_legal      = 1'b1;
                w_dec.rd_we  = 1'b1;
                w_dec.imm    = w_imm_u;
            end
            c_OP_JAL: begin
                w_legal      = 1'b1;
                w_dec.rd_we  = 1'b1;
                w_dec.wb_sel = c_WB_PC4;
                w_dec.is_jal = 1'b1;
                w_dec.imm    = w_imm_j;
            end
            c_OP_JALR: begin
                w_legal       = (w_funct3 == 3'b000);
                w_dec.rd_we   = 1'b1;
                w_dec.wb_sel  = c_WB_PC4;
                w_dec.is_jalr = 1'b1;
                w_dec.imm     = w_imm_i;
            end
            c_OP_BRANCH: begin
                w_legal         = (w_funct3[2:1] != 2'b01);
                w_dec.is_branch = 1'b1;
                w_dec.imm       = w_imm_b;
            end
            c_OP_LOAD: begin
                w_legal        = (w_funct3[1:0] != 2'b11) && (w_funct3 != 3'b110);
                w_dec.rd_we    = 1'b1;
                w_dec.wb_sel   = c_WB_MEM;
                w_dec.mem_read = 1'b1;
                w_dec.mem_size = w_size;
                w_dec.mem_sext = ~w_funct3[2];
                w_dec.imm      = w_imm_i;
            end
            c_OP_STORE: begin
                w_legal         = !w_funct3[2] && (w_funct3[1:0] != 2'b11);
                w_dec.mem_write = 1'b1;
                w_dec.mem_size  = w_size;
                w_dec.imm       = w_imm_s;
            end
            c_OP_IMM: begin
                w_dec.rd_we = 1'b1;
                w_dec.imm   = w_imm_i;
                if (w_funct3 == 3'b001)
                    w_legal = (w_funct7 == 7'b0000000);
                else if (w_funct3 == 3'b101)
                    w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                else
                    w_legal = 1'b1;
            end
            c_OP_OP: begin
                w_dec.rd_we     = 1'b1;
                w_dec.is_muldiv = (w_funct7 == 7'b0000001);
                w_legal = (w_funct7 == 7'b0000000) ||
                          ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))) ||
                          ((w_funct7 == 7'b0000001) && EN_M);
            end
            c_OP_SYSTEM: begin
                if (w_funct3 == 3'b000) begin
                    w_dec.is_ecall  = (in_instr_i[31:20] == 12'h000);
                    w_dec.is_ebreak = (in_instr_i[31:20] == 12'h001);
                    w_dec.is_mret   = (in_instr_i[31:20] == 12'h302);
                    w_legal = w_dec.is_ecall || w_dec.is_ebreak || w_dec.is_mret;
                end else if (w_funct3 != 3'b100) begin
                    w_legal       = 1'b1;
                    w_dec.is_csr  = 1'b1;
                    w_dec.rd_we   = 1'b1;
                    w_dec.wb_sel  = c_WB_CSR;
                    // CSRRxI carries a 5-bit unsigned immediate in the rs1 field
                    if (w_funct3[2])
                        w_dec.imm = {27'b0, in_instr_i[19:15]};
                end
                if (!EN_SYS)
                    w_legal = 1'b0;
            end
            default: w_legal = 1'b0;
        endcase
        if (in_instr_i[1:0] != 2'b11)
            w_legal = 1'b0;
        w_dec.illegal = ~w_legal;
        if (!w_legal) begin
            w_dec.rd_we     = 1'b0;
            w_dec.mem_read  = 1'b0;
            w_dec.mem_write = 1'b0;
            w_dec.is_branch = 1'b0;
            w_dec.is_jal    = 1'b0;
            w_dec.is_jalr   = 1'b0;
            w_dec.is_muldiv = 1'b0;
            w_dec.is_csr    = 1'b0;
            w_dec.is_ecall  = 1'b0;
            w_dec.is_ebreak = 1'b0;
            w_dec.is_mret   = 1'b0;
        end
    end

    assign w_accept = in_valid_i && ready_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (w_accept) begin
                    state_d = S_ONE;
                    out_d   = w_dec;
                end
            end
            S_ONE: begin
                if (w_accept && out_ready_i) begin
                    out_d = w_dec;
                end else if (w_accept) begin
                    state_d = S_TWO;
                    skid_d  = w_dec;
                end else if (out_ready_i) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_ready_i) begin
                    state_d = S_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (flush_i)
            state_d = S_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != S_TWO);
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != S_EMPTY);
    assign out_pc_o    = out_q.pc;
    assign rs1_o       = out_q.rs1;
    assign rs2_o       = out_q.rs2;
    assign rd_o        = out_q.rd;
    assign funct3_o    = out_q.funct3;
    assign imm_o       = out_q.imm;
    assign rd_we_o     = out_q.rd_we;
    assign wb_sel_o    = out_q.wb_sel;
    assign mem_read_o  = out_q.mem_read;
    assign mem_write_o = out_q.mem_write;
    assign mem_size_o  = out_q.mem_size;
    assign mem_sext_o  = out_q.mem_sext;
    assign is_branch_o = out_q.is_branch;
    assign is_jal_o    = out_q.is_jal;
    assign is_jalr_o   = out_q.is_jalr;
    assign is_muldiv_o = out_q.is_muldiv;
    assign is_csr_o    = out_q.is_csr;
    assign is_ecall_o  = out_q.is_ecall;
    assign is_ebreak_o = out_q.is_ebreak;
    assign is_mret_o   = out_q.is_mret;
    assign illegal_o   = out_q.illegal;
endmodule
`default_nettype wire

// File: tb/tb_rv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_decode_stage
// Purpose  : Self-checking bench for rv_decode_stage (full and reduced builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_decode_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic        rd_we;
        logic [2:0]  wb_sel;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_size;
        logic        mem_sext;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_muldiv;
        logic        is_csr;
        logic        is_ecall;
        logic        is_ebreak;
        logic        is_mret;
        logic        illegal;
    } exp_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n, flush_i, in_valid_i, out_ready_i;
    logic [31:0] in_instr_i, in_pc_i;
    logic        in_ready_o, out_valid_o;
    logic        n_in_ready, n_out_valid;
    exp_t        w_act, w_nom;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Full build: M extension and SYSTEM decode enabled
    rv_decode_stage #(.PC_W(32), .EN_M(1'b1), .EN_SYS(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(w_act.pc), .rs1_o(w_act.rs1), .rs2_o(w_act.rs2), .rd_o(w_act.rd),
        .funct3_o(w_act.funct3), .imm_o(w_act.imm), .rd_we_o(w_act.rd_we),
        .wb_sel_o(w_act.wb_sel), .mem_read_o(w_act.mem_read), .mem_write_o(w_act.mem_write),
        .mem_size_o(w_act.mem_size), .mem_sext_o(w_act.mem_sext),
        .is_branch_o(w_act.is_branch), .is_jal_o(w_act.is_jal), .is_jalr_o(w_act.is_jalr),
        .is_muldiv_o(w_act.is_muldiv), .is_csr_o(w_act.is_csr), .is_ecall_o(w_act.is_ecall),
        .is_ebreak_o(w_act.is_ebreak), .is_mret_o(w_act.is_mret), .illegal_o(w_act.illegal)
    );

    // Reduced build driven by the same stimulus
    rv_decode_stage #(.PC_W(32), .EN_M(1'b0), .EN_SYS(1'b0)) u_nom (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(n_in_ready),
        .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
        .out_valid_o(n_out_valid), .out_ready_i(out_ready_i),
        .out_pc_o(w_nom.pc), .rs1_o(w_nom.rs1), .rs2_o(w_nom.rs2), .rd_o(w_nom.rd),
        .funct3_o(w_nom.funct3), .imm_o(w_nom.imm), .rd_we_o(w_nom.rd_we),
        .wb_sel_o(w_nom.wb_sel), .mem_read_o(w_nom.mem_read), .mem_write_o(w_nom.mem_write),
        .mem_size_o(w_nom.mem_size), .mem_sext_o(w_nom.mem_sext),
        .is_branch_o(w_nom.is_branch), .is_jal_o(w_nom.is_jal), .is_jalr_o(w_nom.is_jalr),
        .is_muldiv_o(w_nom.is_muldiv), .is_csr_o(w_nom.is_csr), .is_ecall_o(w_nom.is_ecall),
        .is_ebreak_o(w_nom.is_ebreak), .is_mret_o(w_nom.is_mret), .illegal_o(w_nom.illegal)
    );

    // Reference decoder: immediates rebuilt arithmetically, legality from the instruction tables
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input bit en_m, input bit en_sys);
        exp_t        e;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [11:0] f12;
        int          imm_i, imm_s, imm_b, imm_j;
        bit          ok;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        f12 = ins[31:20];
        imm_i = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
        imm_s = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
        imm_b = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
              + int'(ins[11:8]) * 2;
        imm_j = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
              + int'(ins[30:21]) * 2;
        e = '0;
        e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.funct3 = f3;
        ok = 1'b0;
        case (op)
            7'b0110111: begin ok = 1; e.rd_we = 1; e.wb_sel = 3'd1; e.imm = ins & 32'hFFFFF000; end
            7'b0010111: begin ok = 1; e.rd_we = 1; e.imm = ins & 32'hFFFFF000; end
            7'b1101111: begin ok = 1; e.rd_we = 1; e.wb_sel = 3'd3; e.is_jal = 1; e.imm = imm_j; end
            7'b1100111: begin ok = (f3 == 0); e.rd_we = 1; e.wb_sel = 3'd3; e.is_jalr = 1; e.imm = imm_i; end
            7'b1100011: begin ok = !(f3 inside {3'd2, 3'd3}); e.is_branch = 1; e.imm = imm_b; end
            7'b0000011: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                e.mem_read = 1; e.rd_we = 1; e.wb_sel = 3'd4; e.imm = imm_i;
                e.mem_size = (f3[1:0] == 0) ? 2'b11 : (f3[1:0] == 1) ? 2'b01 : 2'b00;
                e.mem_sext = (f3 < 4);
            end
            7'b0100011: begin
                ok = (f3 <= 2); e.mem_write = 1; e.imm = imm_s;
                e.mem_size = (f3[1:0] == 0) ? 2'b11 : (f3[1:0] == 1) ? 2'b01 : 2'b00;
            end
            7'b0010011: begin
                e.rd_we = 1; e.imm = imm_i;
                ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 inside {7'h00, 7'h20}) : 1'b1;
            end
            7'b0110011: begin
                e.rd_we = 1; e.is_muldiv = (f7 == 7'h01);
                ok = (f7 == 0) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) || (f7 == 7'h01 && en_m);
            end
            7'b1110011: begin
                if (f3 == 0) begin
                    e.is_ecall = (f12 == 12'h000); e.is_ebreak = (f12 == 12'h001);
                    e.is_mret = (f12 == 12'h302);
                    ok = e.is_ecall || e.is_ebreak || e.is_mret;
                end else if (f3 != 4) begin
                    ok = 1; e.is_csr = 1; e.rd_we = 1; e.wb_sel = 3'd5;
                    if (f3 >= 5) e.imm = int'(ins[19:15]);
                end
                ok = ok && en_sys;
            end
            default: ok = 1'b0;
        endcase
        e.illegal = !ok;
        if (!ok) begin
            e.rd_we = 0; e.mem_read = 0; e.mem_write = 0;
            e.is_branch = 0; e.is_jal = 0; e.is_jalr = 0; e.is_muldiv = 0; e.is_csr = 0;
            e.is_ecall = 0; e.is_ebreak = 0; e.is_mret = 0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [11:0] sysf [3];
        logic [31:0] r;
        ops[0] = 7'b0110111; ops[1] = 7'b0010111; ops[2] = 7'b1101111; ops[3] = 7'b1100111;
        ops[4] = 7'b1100011; ops[5] = 7'b0000011; ops[6] = 7'b0100011; ops[7] = 7'b0010011;
        ops[8] = 7'b0110011; ops[9] = 7'b1110011; ops[10] = 7'b0001111;
        sysf[0] = 12'h000; sysf[1] = 12'h001; sysf[2] = 12'h302;
        r = $urandom;
        r[6:0] = ops[$urandom_range(0, 10)];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        if (r[6:0] == 7'b1110011 && $urandom_range(0, 1) == 1) begin
            r[31:20] = sysf[$urandom_range(0, 2)];
            r[14:12] = 3'b000;
        end
        if ($urandom_range(0, 15) == 0) r[1:0] = 2'($urandom_range(0, 2));
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [31:0] ins, input logic [31:0] pc);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_instr_i  = ins;
        in_pc_i     = pc;
        step();
        in_valid_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        in_instr_i = '0; in_pc_i = '0;
        repeat (2) step();
        vectors++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hs: valid=%b ready=%b required valid=0 ready=1", out_valid_o, in_ready_o);
        end
        vectors++;
        if (w_act !== '0) begin
            miscompares++;
            $display("FAIL reset_payload: got %h required 0", w_act);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        send_one(32'h002081B3, 32'h100);
        vectors++;
        if (out_valid_o !== 1'b1 || w_act.rs1 !== 5'd1 || w_act.rs2 !== 5'd2 || w_act.rd !== 5'd3 ||
            w_act.rd_we !== 1'b1 || w_act.wb_sel !== 3'b000 || w_act.illegal !== 1'b0 ||
            w_act.pc !== 32'h100) begin
            miscompares++;
            $display("FAIL basic_add: valid=%b got %h required rs1=1 rs2=2 rd=3 we=1 wb=0 pc=100", out_valid_o, w_act);
        end
        vectors++;
        if (w_act !== model(32'h002081B3, 32'h100, 1, 1)) begin
            miscompares++;
            $display("FAIL basic_model: got %h required %h", w_act, model(32'h002081B3, 32'h100, 1, 1));
        end
        step();
        vectors++;
        if (out_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_drain: valid=%b required 0", out_valid_o);
        end
    endtask

    task automatic test_en_m();
        send_one(32'h022081B3, 32'h104);
        vectors++;
        if (w_act.is_muldiv !== 1'b1 || w_act.illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_enm1: muldiv=%b illegal=%b required 1/0", w_act.is_muldiv, w_act.illegal);
        end
        vectors++;
        if (w_nom.illegal !== 1'b1 || w_nom.rd_we !== 1'b0 || w_nom.is_muldiv !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_enm0: illegal=%b rd_we=%b muldiv=%b required 1/0/0", w_nom.illegal, w_nom.rd_we, w_nom.is_muldiv);
        end
        step();
    endtask

    task automatic test_imm_formats();
        send_one(32'hFE000EE3, 32'h108);
        vectors++;
        if (w_act.imm !== 32'hFFFFFFFC || w_act.is_branch !== 1'b1) begin
            miscompares++;
            $display("FAIL beq_imm: imm=%h br=%b required fffffffc/1", w_act.imm, w_act.is_branch);
        end
        send_one(32'h30200073, 32'h10C);
        vectors++;
        if (w_act.is_mret !== 1'b1 || w_act.illegal !== 1'b0 || w_nom.illegal !== 1'b1 || w_nom.is_mret !== 1'b0) begin
            miscompares++;
            $display("FAIL mret: mret=%b ill=%b nosys_ill=%b required 1/0/1", w_act.is_mret, w_act.illegal, w_nom.illegal);
        end
        send_one(32'h00004003, 32'h110);
        vectors++;
        if (w_act.mem_read !== 1'b1 || w_act.mem_size !== 2'b11 || w_act.mem_sext !== 1'b0 || w_act.wb_sel !== 3'b100) begin
            miscompares++;
            $display("FAIL lbu: rd=%b size=%b sext=%b wb=%b required 1/11/0/100", w_act.mem_read, w_act.mem_size, w_act.mem_sext, w_act.wb_sel);
        end
        send_one(32'h00000000, 32'h114);
        vectors++;
        if (w_act.illegal !== 1'b1) begin
            miscompares++;
            $display("FAIL ill_zero: illegal=%b required 1", w_act.illegal);
        end
        send_one(32'hFFFFFFFF, 32'h118);
        vectors++;
        if (w_act !== model(32'hFFFFFFFF, 32'h118, 1, 1) || w_act.illegal !== 1'b1) begin
            miscompares++;
            $display("FAIL ill_ones: got %h required illegal=1", w_act);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] ins [4];
        int   sent, got;
        logic acc;
        ins[0] = 32'h00500093; ins[1] = 32'h0020A023; ins[2] = 32'hFE000EE3; ins[3] = 32'h00004003;
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready_i = (cyc >= 3);
            in_valid_i  = (sent < 4);
            if (sent < 4) begin
                in_instr_i = ins[sent];
                in_pc_i    = 32'h200 + 32'(4 * sent);
            end
            @(negedge clk);
            if (out_valid_o && out_ready_i) begin
                vectors++;
                if (w_act !== model(ins[got], 32'h200 + 32'(4 * got), 1, 1)) begin
                    miscompares++;
                    $display("FAIL bp_order%0d: got %h required %h", got, w_act, model(ins[got], 32'h200 + 32'(4 * got), 1, 1));
                end
                got++;
            end
            if (cyc == 3) begin
                vectors++;
                if (in_ready_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_hold: in_ready=%b required 0 while full", in_ready_o);
                end
            end
            acc = in_valid_i && in_ready_o;
            step();
            if (acc) begin
                sent++;
                if (sent == 2) begin
                    vectors++;
                    if (in_ready_o !== 1'b0) begin
                        miscompares++;
                        $display("FAIL bp_ready_drop: in_ready=%b required 0", in_ready_o);
                    end
                end
            end
        end
        in_valid_i = 1'b0;
        vectors++;
        if (got != 4 || out_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_count: got %0d outputs valid=%b required 4 and 0", got, out_valid_o);
        end
    endtask

    task automatic test_flush();
        bit leaked = 0;
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        in_instr_i = 32'h00100093; in_pc_i = 32'h300; step();
        in_instr_i = 32'h00200113; in_pc_i = 32'h304; step();
        vectors++;
        if (in_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_full: in_ready=%b required 0", in_ready_o);
        end
        flush_i = 1'b1; out_ready_i = 1'b1;
        in_instr_i = 32'h00300193; in_pc_i = 32'h308; step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        vectors++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_state: valid=%b ready=%b required 0/1", out_valid_o, in_ready_o);
        end
        repeat (4) begin
            step();
            if (out_valid_o !== 1'b0) leaked = 1;
        end
        vectors++;
        if (leaked) begin
            miscompares++;
            $display("FAIL flush_leak: valid=1 seen required 0");
        end
        send_one(32'h00400213, 32'h30C);
        vectors++;
        if (out_valid_o !== 1'b1 || w_act !== model(32'h00400213, 32'h30C, 1, 1)) begin
            miscompares++;
            $display("FAIL flush_after: valid=%b got %h required %h", out_valid_o, w_act, model(32'h00400213, 32'h30C, 1, 1));
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        in_instr_i = 32'h00100093; in_pc_i = 32'h400; step();
        in_instr_i = 32'h30200073; in_pc_i = 32'h404; step();
        rst_n = 1'b0; in_instr_i = 32'h00500093; in_pc_i = 32'h408; step();
        vectors++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || w_act !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: valid=%b ready=%b payload %h required 0/1/0", out_valid_o, in_ready_o, w_act);
        end
        rst_n = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1; step();
        vectors++;
        if (out_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_after: valid=%b required 0", out_valid_o);
        end
    endtask

    task automatic test_random();
        item_t q[$];
        item_t it;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            in_instr_i  = rand_instr();
            in_pc_i     = $urandom;
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 40) == 0);
            @(negedge clk);
            vectors++;
            if (out_valid_o !== (q.size() > 0) || in_ready_o !== (q.size() < 2) ||
                n_out_valid !== out_valid_o) begin
                miscompares++;
                $display("FAIL rnd_hs cyc%0d: valid=%b ready=%b held=%0d", cyc, out_valid_o, in_ready_o, q.size());
            end
            if (flush_i) begin
                q.delete();
            end else begin
                if (out_valid_o && out_ready_i && q.size() > 0) begin
                    it = q.pop_front();
                    vectors++;
                    if (w_act !== model(it.ins, it.pc, 1, 1) || w_nom !== model(it.ins, it.pc, 0, 0)) begin
                        miscompares++;
                        $display("FAIL rnd_data cyc%0d ins=%h: got %h/%h required %h/%h", cyc, it.ins,
                                 w_act, w_nom, model(it.ins, it.pc, 1, 1), model(it.ins, it.pc, 0, 0));
                    end
                end
                if (in_valid_i && in_ready_o) q.push_back('{ins: in_instr_i, pc: in_pc_i});
            end
            step();
        end
        flush_i = 1'b0; in_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_en_m();
        test_imm_formats();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time bound");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/rv_decode_stage.md
# rv_decode_stage

Registered RV32IM instruction-decode stage with valid/ready handshake on both sides, a one-entry skid buffer for full throughput under backpressure, and synchronous flush. Sits between the fetch stage and the execute/issue stage. Turns each 32-bit instruction into register indices, a sign-extended immediate, writeback/memory/control-flow controls and an illegal-instruction flag. Its feature set is selectable per build via parameters.

## Interface
- PC_W, 32, width of the PC carried alongside each instruction
- EN_M, 1, 1 = accept M-extension (funct7 0000001 on opcode 0110011); 0 = flag as illegal
- EN_SYS, 1, 1 = decode CSR/ECALL/EBREAK/MRET; 0 = whole 1110011 opcode is illegal

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous, active-low
- flush_i  in  1  drop every held and incoming instruction
- in_valid_i / in_ready_o  in/out  1/1  upstream handshake
- in_instr_i  in  32  raw instruction
- in_pc_i  in  PC_W  PC of the instruction
- out_valid_o / out_ready_i  out/in  1/1  downstream handshake
- out_pc_o  out  PC_W  PC of the decoded instruction
- rs1_o, rs2_o, rd_o  out  5 each  instr[19:15], [24:20], [11:7]
- funct3_o  out  3  instr[14:12]
- imm_o  out  32  immediate, per format
- rd_we_o  out  1  instruction writes rd
- wb_sel_o  out  3  writeback source: 000 ALU, 001 IMM, 011 PC+4, 100 MEM, 101 CSR
- mem_read_o, mem_write_o  out  1 each  load / store
- mem_size_o  out  2  access size: 00 word, 01 half, 11 byte
- mem_sext_o  out  1  load result sign-extended
- is_branch_o, is_jal_o, is_jalr_o, is_muldiv_o, is_csr_o  out  1 each  instruction class
- is_ecall_o, is_ebreak_o, is_mret_o  out  1 each  system instruction
- illegal_o  out  1  instruction is not legal under the current parameters

## Operation
- **Immediates**
  - I-type, loads, JALR: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U (LUI, AUIPC): {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - CSRRxI: zero-extended instr[19:15].
  - R-type and others: 0.
- **Writeback select**
  - R, I, AUIPC: WB_ALU.
  - LUI: WB_IMM.
  - JAL, JALR: WB_PC4.
  - Loads: WB_MEM.
  - CSR instructions: WB_CSR.
- **rd_we_o** is 1 for R, I, loads, JAL, JALR, LUI, AUIPC and CSR instructions. It is 1 regardless of rd; the register file discards writes to x0.
- **Loads**
  - LB / LH / LW set mem_sext_o = 1; LBU / LHU set it to 0.
  - mem_size_o is taken from funct3[1:0] (000→11, 001→01, 010→00).
- **Illegal conditions** (any one sets illegal_o):
  - instr[1:0] ≠ 11, or unknown opcode.
  - R-type funct7 not in {0000000; 0100000 with funct3 000/101; 0000001 when EN_M}.
  - SLLI funct7 ≠ 0; SRLI/SRAI funct7 ∉ {0000000, 0100000}.
  - Load funct3 ∈ {011, 110, 111}; store funct3 > 010; branch funct3 ∈ {010, 011}; JALR funct3 ≠ 000.
  - SYSTEM funct3 = 100.
  - SYSTEM funct3 000 with funct12 ∉ {0x000 ECALL, 0x001 EBREAK, 0x302 MRET}.
  - Any SYSTEM instruction when EN_SYS = 0.
- **Illegal instructions** still pass downstream with illegal_o = 1. For them rd_we_o, mem_read_o, mem_write_o and every is_* output are forced to 0.
- **Buffering**: one output register plus one skid register.
  - State: EMPTY (out invalid), ONE (output register valid), TWO (output and skid both valid).
  - EMPTY→ONE on accept.
  - ONE→TWO on accept while out_ready_i = 0.
  - TWO→ONE when out_ready_i = 1: the skid entry moves to the output register.
  - ONE→EMPTY when out_ready_i = 1 and nothing is accepted.
  - ONE stays ONE on simultaneous accept and drain.
  - Order is strictly FIFO.

## Timing
- Accept happens when in_valid_i && in_ready_o. Decode is done combinationally before the register, so the result is on the outputs the cycle after accept (latency 1).
- in_ready_o is registered: in_ready_o = (state ≠ TWO). It never depends combinationally on out_ready_i.
- Sustained throughput is 1 instruction per cycle while out_ready_i = 1.
- out_valid_o is held high, with its payload stable, until out_ready_i is sampled high.
- flush_i = 1: next state is EMPTY, and any in_valid_i in the same cycle is dropped. The next cycle has out_valid_o = 0 and in_ready_o = 1. flush_i overrides simultaneous accept and drain.
- Reset (rst_n low at an edge), also when applied mid-operation:
  - state → EMPTY, so out_valid_o = 0 and in_ready_o = 1.
  - All payload outputs = 0, including illegal_o = 0 and wb_sel_o = 000.

## Test plan
- **Basic decode**: 0x002081B3 (ADD x3, x1, x2) at PC 0x100 → one cycle later: out_valid_o = 1, rs1 = 1, rs2 = 2, rd = 3, rd_we = 1, wb_sel = 000, illegal = 0, out_pc = 0x100.
- **EN_M parameter**: 0x022081B3 (MUL) → EN_M = 1: is_muldiv = 1, illegal = 0. EN_M = 0: illegal = 1, rd_we = 0.
- **Immediate formats**:
  - 0xFE000EE3 (BEQ x0, x0, -4) → imm = 0xFFFFFFFC, is_branch = 1.
  - 0x30200073 → is_mret = 1.
  - 0x00004003 (LBU) → mem_read = 1, mem_size = 11, mem_sext = 0, wb_sel = 100.
- **Backpressure**: drive 4 back-to-back instructions A–D with out_ready_i low for 3 cycles.
  - in_ready_o drops the cycle after B is accepted.
  - C is held upstream until the stall releases.
  - Output order is A, B, C, D, with no duplicates or losses.
- **Flush**: flush_i in the TWO state, with in_valid_i high in the same cycle → next cycle out_valid_o = 0 and in_ready_o = 1, and no flushed instruction ever appears at the output.
- **Reset**: rst_n low for 1 cycle while in TWO → out_valid_o = 0, in_ready_o = 1 and all payload outputs = 0 after the edge. Illegal encodings (0x00000000, 0xFFFFFFFF) → illegal = 1.
